// File: rtl/c_ctrl_pkg.sv
// Purpose : shared types and helpers for the clocked control-token blocks.
// Latency : n/a (package only).
// Backpressure: n/a.
// Contents: ctrl_state_e FSM encoding shared by the clocked ctrl blocks,
//           cnt_width() for sizing the free-delay counter.
package c_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRIVE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DLY   = 3'd3,
        ST_FREE  = 3'd4
    } ctrl_state_e;

    // Counter wide enough to hold 0..free_dly, never narrower than one bit.
    function automatic int cnt_width(input int free_dly);
        int w;
        w = $clog2(free_dly + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/c_free_join.sv
// Purpose : sticky per-branch free collector, AND-join and free-delay counter.
// Latency : all_free is combinational from the sticky regs; dly_done after FREE_DLY enabled cycles.
// Backpressure: none; frees are single-cycle pulses and are never refused.
// Ports   : clk, rst (sync, active high); i_free per-branch free pulses;
//           i_en branches allowed to record a free; i_act branches that must free;
//           i_clr clears the sticky regs (a same-cycle free still sets);
//           i_cnt_en runs the delay counter (cleared when low);
//           o_all_free, o_dly_done, o_dup (free on an already-set bit).
module c_free_join
    import c_ctrl_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int FREE_DLY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] i_free,
    input  logic [NUM_CH-1:0] i_en,
    input  logic [NUM_CH-1:0] i_act,
    input  logic              i_clr,
    input  logic              i_cnt_en,
    output logic              o_all_free,
    output logic              o_dly_done,
    output logic              o_dup
);

    localparam int CW = cnt_width(FREE_DLY);
    localparam logic [CW-1:0] DLY_LAST = (FREE_DLY > 0) ? CW'(FREE_DLY - 1) : '0;

    logic [NUM_CH-1:0] free_seen_q, free_seen_d;
    logic [NUM_CH-1:0] free_set;
    logic [CW-1:0]     cnt_q, cnt_d;

    assign free_set = i_free & i_en;

    always_comb begin
        free_seen_d = free_seen_q;
        // Set wins over clear so a free landing in the clear cycle is kept.
        if (i_clr) begin
            free_seen_d = free_set;
        end else begin
            free_seen_d = free_seen_q | free_set;
        end
    end

    always_comb begin
        cnt_d = '0;
        if (i_cnt_en) begin
            // Saturates on the terminal count instead of wrapping.
            cnt_d = (cnt_q != DLY_LAST) ? cnt_q + 1'b1 : cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            free_seen_q <= '0;
            cnt_q       <= '0;
        end else begin
            free_seen_q <= free_seen_d;
            cnt_q       <= cnt_d;
        end
    end

    // Branches outside the active set count as already freed.
    assign o_all_free = &(free_seen_q | ~i_act);
    assign o_dly_done = i_cnt_en && (cnt_q == DLY_LAST);
    assign o_dup      = |(free_set & free_seen_q);

endmodule

// File: rtl/c_nat_split_n_d.sv
// Purpose : clocked N-way unconditional split with registered, held payload.
// Latency : drive out 1 cycle after accepted drive; o_free FREE_DLY+2 cycles after last branch free.
// Backpressure: one token in flight; a drive while busy is dropped and flags o_err.
// Ports   : clk, rst (sync, active high); i_drive/i_data upstream token;
//           o_free upstream release pulse; o_driveNext/o_data per-branch token
//           (ch k at [k*DATA_WIDTH +: DATA_WIDTH]); i_freeNext per-branch release;
//           o_busy token in flight; o_err sticky protocol violation.
// Config  : define CHAN_MASK_EN to add i_chanMask (1 = branch enabled), sampled with i_drive.
module c_nat_split_n_d
    import c_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 10,
    parameter int NUM_CH     = 2,
    parameter int FREE_DLY   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_drive,
    input  logic [DATA_WIDTH-1:0]        i_data,
    output logic                         o_free,
    output logic [NUM_CH-1:0]            o_driveNext,
    output logic [NUM_CH*DATA_WIDTH-1:0] o_data,
    input  logic [NUM_CH-1:0]            i_freeNext,
    output logic                         o_busy,
`ifdef CHAN_MASK_EN
    input  logic [NUM_CH-1:0]            i_chanMask,
`endif
    output logic                         o_err
);

    ctrl_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  err_q, err_d;
    logic [NUM_CH-1:0]     act;
    logic [NUM_CH-1:0]     free_en;
    logic                  all_free;
    logic                  dly_done;
    logic                  free_dup;
    logic                  drive_ok;

`ifdef CHAN_MASK_EN
    logic [NUM_CH-1:0] mask_q, mask_d;
    assign act = mask_q;
`else
    assign act = {NUM_CH{1'b1}};
`endif

    assign drive_ok = i_drive && (state_q == ST_IDLE);

    // The mask of the next token is unknown in IDLE, so frees arriving early
    // are recorded on every branch; once a token is in flight only active
    // branches can record or complain.
    assign free_en = (state_q == ST_IDLE) ? {NUM_CH{1'b1}} : act;

    c_free_join #(
        .NUM_CH   (NUM_CH),
        .FREE_DLY (FREE_DLY)
    ) u_join (
        .clk        (clk),
        .rst        (rst),
        .i_free     (i_freeNext),
        .i_en       (free_en),
        .i_act      (act),
        .i_clr      (state_q == ST_FREE),
        .i_cnt_en   (state_q == ST_DLY),
        .o_all_free (all_free),
        .o_dly_done (dly_done),
        .o_dup      (free_dup)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
`ifdef CHAN_MASK_EN
        mask_d  = mask_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_drive) begin
                    state_d = ST_DRIVE;
                    data_d  = i_data;
`ifdef CHAN_MASK_EN
                    mask_d  = i_chanMask;
`endif
                end
            end
            ST_DRIVE: begin
                // No active branch: nothing to wait for.
                if (act == '0) begin
                    state_d = (FREE_DLY == 0) ? ST_FREE : ST_DLY;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (all_free) begin
                    state_d = (FREE_DLY == 0) ? ST_FREE : ST_DLY;
                end
            end
            ST_DLY: begin
                if (dly_done) begin
                    state_d = ST_FREE;
                end
            end
            ST_FREE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        err_d = err_q | (i_drive && !drive_ok) | free_dup;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            err_q   <= 1'b0;
`ifdef CHAN_MASK_EN
            mask_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            err_q   <= err_d;
`ifdef CHAN_MASK_EN
            mask_q  <= mask_d;
`endif
        end
    end

    // Outputs decode straight from registered state; no input-to-output paths.
    assign o_driveNext = (state_q == ST_DRIVE) ? act : '0;
    assign o_free      = (state_q == ST_FREE);
    assign o_busy      = (state_q != ST_IDLE);
    assign o_data      = {NUM_CH{data_q}};
    assign o_err       = err_q;

endmodule

// File: tb/tb_c_nat_split_n_d.sv
module tb_c_nat_split_n_d;

    localparam int DW = 10;
`ifdef CHAN_MASK_EN
    localparam int NCH = 4;
`else
    localparam int NCH = 2;
`endif
    localparam int FD = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_drive;
    logic [DW-1:0]     i_data;
    logic              o_free;
    logic [NCH-1:0]    o_drive_next;
    logic [NCH*DW-1:0] o_data;
    logic [NCH-1:0]    i_free_next;
    logic              o_busy;
    logic              o_err;
`ifdef CHAN_MASK_EN
    logic [NCH-1:0]    i_chan_mask;
`endif

    c_nat_split_n_d #(
        .DATA_WIDTH (DW),
        .NUM_CH     (NCH),
        .FREE_DLY   (FD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_drive     (i_drive),
        .i_data      (i_data),
        .o_free      (o_free),
        .o_driveNext (o_drive_next),
        .o_data      (o_data),
        .i_freeNext  (i_free_next),
        .o_busy      (o_busy),
`ifdef CHAN_MASK_EN
        .i_chanMask  (i_chan_mask),
`endif
        .o_err       (o_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference state: payload every branch should show and sticky error.
    logic [DW-1:0] exp_data;
    bit            exp_err;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, act, exp);
        end
    endtask

    // Outputs are observed 1 time unit after the edge that starts a cycle.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        rst         = 1'b0;
        i_drive     = 1'b0;
        i_data      = '0;
        i_free_next = '0;
`ifdef CHAN_MASK_EN
        i_chan_mask = '0;
`endif
    endtask

    task automatic check_outs(input bit e_free, input logic [NCH-1:0] e_dn, input bit e_busy);
        check("o_free", o_free, e_free);
        check("o_driveNext", o_drive_next, e_dn);
        check("o_busy", o_busy, e_busy);
        check("o_err", o_err, exp_err);
        for (int k = 0; k < NCH; k++) begin
            check("o_data", o_data[k*DW +: DW], exp_data);
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_data = '0;
        exp_err  = 1'b0;
        check_outs(1'b0, '0, 1'b0);
    endtask

    // One token. rel[k]: cycle offset from the drive cycle at which branch k
    // frees (>=1). pre_ch: branch that frees in an idle cycle before the drive
    // (-1 for none). bad_at: offset of an illegal second drive (0 = none).
    // rst_dly: pulse reset in the last cycle before o_free would appear.
    task automatic run_txn(input logic [DW-1:0] data, input logic [NCH-1:0] mask,
                           input int rel[NCH], input int pre_ch, input int bad_at,
                           input logic [DW-1:0] bad_data, input bit rst_dly);
        int c0;
        int last;
        int f_cyc;
        bit did_rst;
        if (pre_ch >= 0) begin
            idle_inputs();
            i_free_next[pre_ch] = 1'b1;
            step();
            check_outs(1'b0, '0, 1'b0);
        end
        c0   = cyc;
        last = -1;
        for (int k = 0; k < NCH; k++) begin
            if (mask[k] && k != pre_ch && c0 + rel[k] > last) last = c0 + rel[k];
        end
        // Last missing free sampled at cycle L -> o_free at L+FD+2; with no
        // active branch o_free comes FD+1 cycles after the drive-out cycle.
        f_cyc = (mask == '0) ? c0 + FD + 2 : last + FD + 2;
        for (int c = c0; c <= f_cyc; c++) begin
            idle_inputs();
            if (c == c0) begin
                i_drive = 1'b1;
                i_data  = data;
`ifdef CHAN_MASK_EN
                i_chan_mask = mask;
`endif
            end else if (bad_at > 0 && c == c0 + bad_at) begin
                i_drive = 1'b1;
                i_data  = bad_data;
`ifdef CHAN_MASK_EN
                i_chan_mask = ~mask;
`endif
            end
            for (int k = 0; k < NCH; k++) begin
                if (k != pre_ch && c == c0 + rel[k]) i_free_next[k] = 1'b1;
            end
            did_rst = rst_dly && (c == f_cyc - 1);
            rst = did_rst;
            step();
            if (did_rst) begin
                exp_data = '0;
                exp_err  = 1'b0;
                check_outs(1'b0, '0, 1'b0);
                idle_inputs();
                // Abandoned token must never release upstream.
                step();
                check_outs(1'b0, '0, 1'b0);
                return;
            end
            if (cyc == c0 + 1) exp_data = data;
            if (bad_at > 0 && c == c0 + bad_at) exp_err = 1'b1;
            check_outs(cyc == f_cyc, (cyc == c0 + 1) ? mask : '0,
                       (cyc >= c0 + 1) && (cyc <= f_cyc));
        end
        idle_inputs();
    endtask

    initial begin
        int rel[NCH];
        logic [NCH-1:0] all_on;
        logic [NCH-1:0] m;
        int pre;
        int bad;
        all_on   = '1;
        exp_data = '0;
        exp_err  = 1'b0;
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        check_outs(1'b0, '0, 1'b0);
        rst = 1'b0;

        // Frees at +3 and +6 -> o_free at +10.
        for (int k = 0; k < NCH; k++) rel[k] = 2 + k;
        rel[0] = 3;
        rel[1] = 6;
        run_txn(10'h2A5, all_on, rel, -1, 0, '0, 1'b0);

        // ch1 free arrives while idle; ch0 at +3 -> o_free at +7.
        rel[0] = 3;
        rel[1] = 1;
        run_txn(10'h2A5, all_on, rel, 1, 0, '0, 1'b0);

        // Illegal drive while waiting: data held, sticky error.
        rel[0] = 3;
        rel[1] = 6;
        run_txn(10'h2A5, all_on, rel, -1, 2, 10'h111, 1'b0);
        step();
        check_outs(1'b0, '0, 1'b0);
        do_reset();

        // Reset in the delay phase, then a clean token.
        run_txn(10'h2A5, all_on, rel, -1, 0, '0, 1'b1);
        run_txn(10'h2A5, all_on, rel, -1, 0, '0, 1'b0);

`ifdef CHAN_MASK_EN
        // Masked branch ch1 frees mid-token: ignored, no error.
        rel[0] = 3;
        rel[1] = 2;
        rel[2] = 6;
        rel[3] = 4;
        run_txn(10'h0F3, 4'b0101, rel, -1, 0, '0, 1'b0);
        run_txn(10'h155, 4'b0000, rel, -1, 0, '0, 1'b0);
`endif

        for (int t = 0; t < 60; t++) begin
            for (int k = 0; k < NCH; k++) rel[k] = $urandom_range(1, 8);
`ifdef CHAN_MASK_EN
            m = NCH'($urandom_range(0, (1 << NCH) - 1));
`else
            m = all_on;
`endif
            pre = -1;
            if ($countones(m) >= 2 && $urandom_range(0, 3) == 0) begin
                for (int k = 0; k < NCH; k++) if (m[k]) pre = k;
            end
            bad = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0;
            run_txn(DW'($urandom), m, rel, pre, bad, DW'($urandom), 1'b0);
            if (bad > 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
